// File: rtl/potential_adder.sv
// -----------------------------------------------------------------------------
// potential_adder
//
// Per-neuron membrane-potential integrator. Loads the decayed potential from
// the decay stage and adds buffered FP32 synaptic weights into it, one add
// per cycle. On the rising edge of clear it drains the weights that belong
// to the current timestep, compares the result against the threshold, and
// returns the new potential (with a spike if the threshold was reached).
//
// Ports:
//   CLK, reset_n            clock, asynchronous active-low reset
//   clear                   timestep boundary (level; rising edge acted on)
//   neuron_address          address reported with a spike
//   decayed_potential/valid FP32 potential from decay stage, one-cycle valid
//   weight_in/valid/ready   FP32 weight stream into the FIFO
//   threshold               FP32 firing threshold, sampled in CHECK
//   reset_potential         FP32 potential loaded after a spike
//   new_potential/valid     FP32 potential to decay stage, one-cycle valid
//   spike_out/spike_address spike pulse and captured neuron address
//   add_exception           sticky adder exception flag
//   busy                    high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------

// Combinational FP32 adder/subtractor. Round-to-nearest-even, subnormal
// inputs and results flushed to zero. exception flags Inf/NaN operands and
// overflow to infinity.
module addition_subtraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        exception
);
    logic               swap;
    logic [31:0]        x, y;
    logic [7:0]         ex, ey, d;
    logic [23:0]        mx, my;
    logic [26:0]        my_ext, aligned, norm;
    logic               sticky;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [9:0]  e;
    logic               round_up;
    logic [24:0]        mant_r;
    logic [23:0]        mant;
    logic               a_ff, b_ff, a_nan, b_nan;

    always_comb begin
        // NOTE: every variable gets a value on every path through an
        // always_comb block; a missed branch would infer a latch.
        result    = 32'd0;
        exception = 1'b0;
        lz        = 5'd0;
        sticky    = 1'b0;
        aligned   = 27'd0;
        norm      = 27'd0;
        mant      = 24'd0;

        // Larger magnitude operand goes to x so the alignment shift is one-sided.
        swap = (b[30:0] > a[30:0]);
        x    = swap ? b : a;
        y    = swap ? a : b;
        ex   = x[30:23];
        ey   = y[30:23];
        mx   = (ex != 8'd0) ? {1'b1, x[22:0]} : 24'd0;
        my   = (ey != 8'd0) ? {1'b1, y[22:0]} : 24'd0;
        d    = ex - ey;

        // Three extra bits below the LSB (guard, round, sticky).
        my_ext = {my, 3'b000};
        if (d >= 8'd27) begin
            aligned = 27'd0;
            sticky  = |my;
        end else begin
            aligned = my_ext >> d;
            sticky  = |(my_ext & ~({27{1'b1}} << d));
        end
        aligned[0] = aligned[0] | sticky;

        if (x[31] ^ y[31])
            sum = {1'b0, mx, 3'b000} - {1'b0, aligned};
        else
            sum = {1'b0, mx, 3'b000} + {1'b0, aligned};

        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);

        e = $signed({2'b00, ex});
        if (sum[27]) begin
            norm = sum[27:1] | {26'd0, sum[0]};
            e    = e + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            e    = e - $signed({5'd0, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            mant = mant_r[24:1];
            e    = e + 10'sd1;
        end else begin
            mant = mant_r[23:0];
        end

        a_ff  = (a[30:23] == 8'hFF);
        b_ff  = (b[30:23] == 8'hFF);
        a_nan = a_ff && (a[22:0] != 23'd0);
        b_nan = b_ff && (b[22:0] != 23'd0);

        if (a_ff || b_ff) begin
            exception = 1'b1;
            if (a_nan || b_nan || (a_ff && b_ff && (a[31] != b[31])))
                result = 32'h7FC0_0000;
            else
                result = a_ff ? a : b;
        end else if (sum == 28'd0) begin
            result = {x[31] & y[31], 31'd0};
        end else if (e >= 10'sd255) begin
            exception = 1'b1;
            result    = {x[31], 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            result = {x[31], 31'd0};
        end else begin
            result = {x[31], e[7:0], mant[22:0]};
        end
    end
endmodule

module potential_adder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [ADDR_W-1:0] neuron_address,
    input  logic [31:0]       decayed_potential,
    input  logic              decayed_valid,
    input  logic [31:0]       weight_in,
    input  logic              weight_valid,
    output logic              weight_ready,
    input  logic [31:0]       threshold,
    input  logic [31:0]       reset_potential,
    output logic [31:0]       new_potential,
    output logic              new_potential_valid,
    output logic              spike_out,
    output logic [ADDR_W-1:0] spike_address,
    output logic              add_exception,
    output logic              busy
);
    localparam int             PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]       state;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next, drain_left;
    logic [31:0]      acc, head, sum;
    logic             clear_q, clear_rise;
    logic             push, pop, fire, add_exc;

    // FP32 a >= b. Equal zeros of either sign compare equal; NaN never fires.
    function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
        logic a_nan, b_nan;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan)                           return 1'b0;
        if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) return 1'b1;
        if (a[31] != b[31])                           return !a[31];
        if (!a[31])                                   return a[30:0] >= b[30:0];
        return a[30:0] <= b[30:0];
    endfunction

    addition_subtraction u_add (
        .a         (acc),
        .b         (head),
        .result    (sum),
        .exception (add_exc)
    );

    // Ready depends only on the registered count, so a push is refused while
    // full even if a pop frees a slot in the same cycle.
    assign weight_ready = (count != FULL_COUNT);
    assign push         = weight_valid && weight_ready;
    // In DRAIN only the entries present at DRAIN entry are consumed.
    assign pop          = ((state == S_ACCUM) && (count != '0)) ||
                          ((state == S_DRAIN) && (drain_left != '0));
    assign head         = fifo_mem[rd_ptr];
    assign clear_rise   = clear && !clear_q;
    assign busy         = (state != S_IDLE);
    assign fire         = fp_ge(acc, threshold);

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (!push && pop) count_next = count - 1'b1;
    end

    // NOTE: storage array carries no reset; validity is tracked entirely by
    // the pointers and count, which are reset.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= weight_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            count               <= '0;
            drain_left          <= '0;
            acc                 <= 32'd0;
            clear_q             <= 1'b0;
            new_potential       <= 32'd0;
            new_potential_valid <= 1'b0;
            spike_out           <= 1'b0;
            spike_address       <= '0;
            add_exception       <= 1'b0;
        end else begin
            clear_q             <= clear;
            count               <= count_next;
            new_potential_valid <= 1'b0;
            spike_out           <= 1'b0;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_W'(1);
                acc           <= sum;
                add_exception <= add_exception | add_exc;
            end

            case (state)
                S_IDLE: begin
                    if (decayed_valid) begin
                        acc   <= decayed_potential;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (clear_rise) begin
                        // Includes a weight accepted in this same cycle.
                        drain_left <= count_next;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_left == '0) state <= S_CHECK;
                    else                  drain_left <= drain_left - 1'b1;
                end
                S_CHECK: begin
                    new_potential_valid <= 1'b1;
                    if (fire) begin
                        spike_out     <= 1'b1;
                        spike_address <= neuron_address;
                        new_potential <= reset_potential;
                    end else begin
                        new_potential <= acc;
                    end
                    state <= S_OUT;
                end
                S_OUT:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_potential_adder.sv
// -----------------------------------------------------------------------------
// tb_potential_adder
//
// Directed bench for potential_adder. Each timestep pushes its expected
// result into a scoreboard queue; an independent monitor pops and compares
// whenever new_potential_valid is presented.
// -----------------------------------------------------------------------------
module tb_potential_adder;
    logic        CLK;
    logic        reset_n;
    logic        clear;
    logic [11:0] neuron_address;
    logic [31:0] decayed_potential;
    logic        decayed_valid;
    logic [31:0] weight_in;
    logic        weight_valid;
    logic        weight_ready;
    logic [31:0] threshold;
    logic [31:0] reset_potential;
    logic [31:0] new_potential;
    logic        new_potential_valid;
    logic        spike_out;
    logic [11:0] spike_address;
    logic        add_exception;
    logic        busy;

    typedef struct packed {
        logic [31:0] np;
        logic        spike;
        logic [11:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    potential_adder #(.FIFO_DEPTH(4), .ADDR_W(12)) dut (
        .CLK                 (CLK),
        .reset_n             (reset_n),
        .clear               (clear),
        .neuron_address      (neuron_address),
        .decayed_potential   (decayed_potential),
        .decayed_valid       (decayed_valid),
        .weight_in           (weight_in),
        .weight_valid        (weight_valid),
        .weight_ready        (weight_ready),
        .threshold           (threshold),
        .reset_potential     (reset_potential),
        .new_potential       (new_potential),
        .new_potential_valid (new_potential_valid),
        .spike_out           (spike_out),
        .spike_address       (spike_address),
        .add_exception       (add_exception),
        .busy                (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every presented result is matched against the scoreboard.
    always @(negedge CLK) begin
        if (reset_n === 1'b1) begin
            if (spike_out && !new_potential_valid) begin
                checks++;
                errors++;
                $display("FAIL spike_gate: spike_out=1 while new_potential_valid=0");
            end
            if (new_potential_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: new_potential=%h with empty scoreboard", new_potential);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("new_potential", new_potential, e.np);
                    check("spike_out", {31'd0, spike_out}, {31'd0, e.spike});
                    if (e.spike) check("spike_address", {20'd0, spike_address}, {20'd0, e.addr});
                end
            end
        end
    end

    task automatic setup(input logic [31:0] thr, input logic [31:0] rp, input logic [11:0] addr);
        threshold       = thr;
        reset_potential = rp;
        neuron_address  = addr;
    endtask

    task automatic load_decayed(input logic [31:0] p);
        @(negedge CLK);
        decayed_potential = p;
        decayed_valid     = 1'b1;
        @(negedge CLK);
        decayed_valid     = 1'b0;
    endtask

    // Leaves weight_valid high; the transfer happens on the next rising edge.
    task automatic push_weight(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge CLK);
        weight_in    = w;
        weight_valid = 1'b1;
        while (!weight_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!weight_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: weight_ready=0, required 1 within 100 cycles");
        end
    endtask

    task automatic end_weights();
        @(negedge CLK);
        weight_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 64);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=1, required 0 within 64 cycles");
        end
    endtask

    task automatic finish_ts(input logic [31:0] np, input logic spike, input logic [11:0] addr);
        sb_q.push_back('{np: np, spike: spike, addr: addr});
        @(negedge CLK);
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        wait_idle();
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; neuron_address = '0;
        decayed_potential = '0; decayed_valid = 1'b0;
        weight_in = '0; weight_valid = 1'b0;
        threshold = '0; reset_potential = '0;

        repeat (2) @(negedge CLK);
        check("rst_weight_ready", {31'd0, weight_ready}, 32'd1);
        check("rst_new_potential", new_potential, 32'd0);
        check("rst_valid", {31'd0, new_potential_valid}, 32'd0);
        check("rst_spike", {31'd0, spike_out}, 32'd0);
        check("rst_spike_address", {20'd0, spike_address}, 32'd0);
        check("rst_add_exception", {31'd0, add_exception}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        // 0.5 + 0.5 + 0.5 = 1.5 < 2.0
        setup(32'h4000_0000, 32'h3E80_0000, 12'h001);
        load_decayed(32'h3F00_0000);
        push_weight(32'h3F00_0000);
        push_weight(32'h3F00_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h3FC0_0000, 1'b0, 12'h001);

        // 1.0 + 1.0 = 2.0 >= 1.5 -> spike, reset to 0
        setup(32'h3FC0_0000, 32'h0000_0000, 12'h02A);
        load_decayed(32'h3F80_0000);
        push_weight(32'h3F80_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h0000_0000, 1'b1, 12'h02A);

        // Exact equality 1.5 >= 1.5 fires
        setup(32'h3FC0_0000, 32'h3F00_0000, 12'h155);
        load_decayed(32'h3F00_0000);
        push_weight(32'h3F00_0000);
        push_weight(32'h3F00_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h3F00_0000, 1'b1, 12'h155);

        // -1.0 + 3.0 = 2.0: fires against 1.5, and value visible against 3.0
        setup(32'h3FC0_0000, 32'h0000_0000, 12'h0AB);
        load_decayed(32'hBF80_0000);
        push_weight(32'h4040_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h0000_0000, 1'b1, 12'h0AB);

        setup(32'h4040_0000, 32'h0000_0000, 12'h0AC);
        load_decayed(32'hBF80_0000);
        push_weight(32'h4040_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h4000_0000, 1'b0, 12'h0AC);

        // NaN threshold never fires
        setup(32'h7FC0_0000, 32'h0000_0000, 12'h0CD);
        load_decayed(32'h4000_0000);
        repeat (2) @(negedge CLK);
        finish_ts(32'h4000_0000, 1'b0, 12'h0CD);

        // Buffering: four weights fill the FIFO in IDLE, the fifth is held
        setup(32'h4100_0000, 32'h0000_0000, 12'h0B0);
        for (int i = 0; i < 4; i++) push_weight(32'h3F80_0000);
        @(negedge CLK);
        check("full_ready", {31'd0, weight_ready}, 32'd0);
        repeat (2) @(negedge CLK);
        check("held_ready", {31'd0, weight_ready}, 32'd0);
        check("held_busy", {31'd0, busy}, 32'd0);
        decayed_potential = 32'h3F80_0000;
        decayed_valid     = 1'b1;
        @(negedge CLK);
        decayed_valid = 1'b0;
        check("accum_entry_ready", {31'd0, weight_ready}, 32'd0);
        @(negedge CLK);
        check("after_first_pop_ready", {31'd0, weight_ready}, 32'd1);
        @(negedge CLK);
        weight_valid = 1'b0;
        repeat (6) @(negedge CLK);
        finish_ts(32'h40C0_0000, 1'b0, 12'h0B0);

        // Latency with an empty FIFO; clear then stays high
        setup(32'h4000_0000, 32'h0000_0000, 12'h0D0);
        load_decayed(32'h3F80_0000);
        repeat (2) @(negedge CLK);
        sb_q.push_back('{np: 32'h3F80_0000, spike: 1'b0, addr: 12'h0D0});
        clear = 1'b1;
        @(negedge CLK);
        check("lat_edge1_valid", {31'd0, new_potential_valid}, 32'd0);
        @(negedge CLK);
        check("lat_edge2_valid", {31'd0, new_potential_valid}, 32'd0);
        @(negedge CLK);
        check("lat_edge3_valid", {31'd0, new_potential_valid}, 32'd1);
        wait_idle();

        // Clear still high: the next timestep must not see another edge
        setup(32'h4040_0000, 32'h0000_0000, 12'h0D1);
        load_decayed(32'h4000_0000);
        repeat (10) @(negedge CLK);
        check("held_clear_busy", {31'd0, busy}, 32'd1);
        clear = 1'b0;
        finish_ts(32'h4000_0000, 1'b0, 12'h0D1);

        // clear edge in IDLE is ignored
        @(negedge CLK);
        clear = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_clear_busy", {31'd0, busy}, 32'd0);
        clear = 1'b0;

        // Inf weight raises the sticky exception; inf >= 1.5 fires
        check("exc_before", {31'd0, add_exception}, 32'd0);
        setup(32'h3FC0_0000, 32'h3E00_0000, 12'h3C3);
        load_decayed(32'h3F80_0000);
        push_weight(32'h7F80_0000);
        end_weights();
        repeat (4) @(negedge CLK);
        finish_ts(32'h3E00_0000, 1'b1, 12'h3C3);
        check("exc_sticky", {31'd0, add_exception}, 32'd1);

        // Reset during DRAIN with two entries still queued
        setup(32'h4080_0000, 32'h0000_0000, 12'h0E0);
        for (int i = 0; i < 4; i++) push_weight(32'h3F80_0000);
        end_weights();
        decayed_potential = 32'h3F80_0000;
        decayed_valid     = 1'b1;
        @(negedge CLK);
        decayed_valid = 1'b0;
        clear         = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        @(negedge CLK);
        check("drain_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, weight_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, new_potential_valid}, 32'd0);
        check("mid_rst_new_potential", new_potential, 32'd0);
        check("mid_rst_spike_address", {20'd0, spike_address}, 32'd0);
        check("mid_rst_exception", {31'd0, add_exception}, 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;

        // Any stale FIFO entry would be added into this timestep
        load_decayed(32'h4040_0000);
        repeat (6) @(negedge CLK);
        finish_ts(32'h4040_0000, 1'b0, 12'h0E0);

        repeat (4) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
